// File: rtl/argmax_classifier_pkg.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier_pkg
// Purpose  : Shared constants and FSM encoding for the argmax classifier.
//            DEF_N_CLASS / DEF_W are the default class count and sum width;
//            DIGIT_W is the fixed width of the winning-class index output.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package argmax_classifier_pkg;

  localparam int DEF_N_CLASS = 10;
  localparam int DEF_W       = 26;
  localparam int DIGIT_W     = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPARE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage : argmax_classifier_pkg
`default_nettype wire

// File: rtl/argmax_classifier_if.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier_if
// Purpose  : Bundles the neuron-sum input side and the classification result
//            side of the argmax classifier.
// Ports    : master - drives Sum_In / Sum_Valid, observes results
//            slave  - consumes sums, drives Digit / Max_Value / Output_Valid /
//                     Busy / Overrun
// Revision : 1.0 - initial release
// ============================================================================
interface argmax_classifier_if
  import argmax_classifier_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int W       = DEF_W
);

  logic [N_CLASS*W-1:0] Sum_In;
  logic [N_CLASS-1:0]   Sum_Valid;
  logic [DIGIT_W-1:0]   Digit;
  logic [W-1:0]         Max_Value;
  logic                 Output_Valid;
  logic                 Busy;
  logic                 Overrun;

  modport master (
    output Sum_In, Sum_Valid,
    input  Digit, Max_Value, Output_Valid, Busy, Overrun
  );

  modport slave (
    input  Sum_In, Sum_Valid,
    output Digit, Max_Value, Output_Valid, Busy, Overrun
  );

endinterface : argmax_classifier_if
`default_nettype wire

// File: rtl/argmax_classifier_sum_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : sum_capture_bank
// Purpose  : N_CLASS sum registers with per-class capture flags. A capture
//            bit loads its slice and sets its flag; i_clear drops all flags
//            (register contents are kept, they are simply no longer valid).
// Ports    : clk, rst (async, active-low)
//            i_capture      - per-class load enables
//            i_data         - concatenated sums, class k at [k*W +: W]
//            i_clear        - clear all capture flags
//            o_bank         - stored sums
//            o_flags        - capture flags
//            o_all_captured - every flag set
// Revision : 1.0 - initial release
// ============================================================================
module sum_capture_bank #(
  parameter int N_CLASS = 10,
  parameter int W       = 26
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CLASS-1:0]          i_capture,
  input  logic [N_CLASS*W-1:0]        i_data,
  input  logic                        i_clear,
  output logic [N_CLASS-1:0][W-1:0]   o_bank,
  output logic [N_CLASS-1:0]          o_flags,
  output logic                        o_all_captured
);

  logic [N_CLASS-1:0][W-1:0] bank_q, bank_d;
  logic [N_CLASS-1:0]        flag_q, flag_d;

  always_comb begin
    bank_d = bank_q;
    flag_d = flag_q;
    if (i_clear) begin
      flag_d = '0;
    end else begin
      for (int k = 0; k < N_CLASS; k++) begin
        if (i_capture[k]) begin
          bank_d[k] = i_data[k*W +: W];
          flag_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
      flag_q <= '0;
    end else begin
      bank_q <= bank_d;
      flag_q <= flag_d;
    end
  end

  assign o_bank         = bank_q;
  assign o_flags        = flag_q;
  assign o_all_captured = &flag_q;

endmodule : sum_capture_bank
`default_nettype wire

// File: rtl/argmax_classifier.sv
`default_nettype none
// ============================================================================
// Module   : argmax_classifier
// Purpose  : Collects N_CLASS signed neuron sums, then scans them one per
//            cycle to find the largest (lowest index wins ties) and reports
//            its index and value with a one-cycle Output_Valid pulse.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous active-low reset
//            bus  - argmax_classifier_if slave (Sum_In, Sum_Valid in;
//                   Digit, Max_Value, Output_Valid, Busy, Overrun out)
// Revision : 1.0 - initial release
// ============================================================================
module argmax_classifier
  import argmax_classifier_pkg::*;
#(
  parameter int N_CLASS = DEF_N_CLASS,
  parameter int W       = DEF_W
) (
  input  logic                 clk,
  input  logic                 rst,
  argmax_classifier_if.slave   bus
);

  // idx must be able to hold N_CLASS: the scan uses one extra cycle with
  // idx == N_CLASS to publish the result, which sets the fixed latency.
  localparam int IDX_W = $clog2(N_CLASS + 1);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [W-1:0]              best_q, best_d;
  logic [DIGIT_W-1:0]        best_idx_q, best_idx_d;
  logic [DIGIT_W-1:0]        digit_q, digit_d;
  logic [W-1:0]              max_q, max_d;

  logic [N_CLASS-1:0][W-1:0] w_bank;
  logic [N_CLASS-1:0]        w_flags;
  logic                      w_all_captured;
  logic                      w_clear;
  logic [N_CLASS-1:0]        w_capture;
  logic [W-1:0]              w_cand;

  // Sums are only accepted while collecting; anything else is dropped.
  assign w_capture = (state_q == ST_COLLECT) ? bus.Sum_Valid : '0;

  sum_capture_bank #(
    .N_CLASS (N_CLASS),
    .W       (W)
  ) u_bank (
    .clk            (clk),
    .rst            (rst),
    .i_capture      (w_capture),
    .i_data         (bus.Sum_In),
    .i_clear        (w_clear),
    .o_bank         (w_bank),
    .o_flags        (w_flags),
    .o_all_captured (w_all_captured)
  );

  // Candidate mux written as a compare loop so idx == N_CLASS stays in range.
  always_comb begin
    w_cand = '0;
    for (int k = 0; k < N_CLASS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_cand = w_bank[k];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    digit_d    = digit_q;
    max_d      = max_q;
    w_clear    = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (w_all_captured) begin
          state_d    = ST_COMPARE;
          best_d     = w_bank[0];
          best_idx_d = '0;
          idx_d      = IDX_W'(1);
        end
      end
      ST_COMPARE: begin
        if (idx_q == IDX_W'(N_CLASS)) begin
          state_d = ST_DONE;
          digit_d = best_idx_q;
          max_d   = best_q;
        end else begin
          // Strictly greater: equal values keep the earlier index.
          if ($signed(w_cand) > $signed(best_q)) begin
            best_d     = w_cand;
            best_idx_d = DIGIT_W'(idx_q);
          end
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_COLLECT;
        w_clear = 1'b1;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_COLLECT;
      idx_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      digit_q    <= '0;
      max_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      digit_q    <= digit_d;
      max_q      <= max_d;
    end
  end

  assign bus.Digit        = digit_q;
  assign bus.Max_Value    = max_q;
  assign bus.Output_Valid = (state_q == ST_DONE);
  assign bus.Busy         = (state_q != ST_COLLECT);
  // Dropped = repeat capture while collecting, or any valid while busy.
  assign bus.Overrun      = (state_q == ST_COLLECT) ? |(bus.Sum_Valid & w_flags)
                                                    : |bus.Sum_Valid;

endmodule : argmax_classifier
`default_nettype wire

// File: doc/argmax_classifier.md
ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N_CLASS, default 10, meaning number of neuron sums per frame.
REQ-002 SHALL have parameter W, default 26, meaning width of each neuron sum (two's-complement fixed point).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port Sum_In  input  N_CLASS*W  concatenated neuron sums, class k at bits [k*W +: W].
REQ-006 SHALL have port Sum_Valid  input  N_CLASS  per-class one-cycle valid pulses, bit k qualifies slice k.
REQ-007 SHALL have port Digit  output  4  index of the largest captured sum.
REQ-008 SHALL have port Max_Value  output  W  value of the largest captured sum.
REQ-009 SHALL have port Output_Valid  output  1  one-cycle pulse qualifying Digit and Max_Value.
REQ-010 SHALL have port Busy  output  1  high while in COMPARE or DONE.
REQ-011 SHALL have port Overrun  output  1  one-cycle pulse when any Sum_Valid bit is dropped.

Function
REQ-012 SHALL implement the FSM states COLLECT, COMPARE, DONE.
REQ-013 In COLLECT, each set Sum_Valid[k] SHALL latch slice k into bank register k and set capture flag k, with any number of bits accepted in the same cycle.
REQ-014 A repeated Sum_Valid[k] in COLLECT with flag k already set SHALL overwrite register k and pulse Overrun.
REQ-015 When all N_CLASS flags are set after an edge, the next edge SHALL enter COMPARE with best=reg0, best_idx=0, idx=1.
REQ-016 COMPARE SHALL evaluate one class per cycle: if reg[idx] > best (signed compare), then best=reg[idx] and best_idx=idx; then idx increments.
REQ-017 Ties SHALL keep the lower index.
REQ-018 After idx=N_CLASS-1 is evaluated, the FSM SHALL enter DONE.
REQ-019 In DONE, Output_Valid SHALL be high for exactly one cycle with Digit=best_idx and Max_Value=best; the next edge SHALL clear all flags and return to COLLECT.
REQ-020 Digit and Max_Value SHALL hold their last values until the next DONE.
REQ-021 Latency: Output_Valid SHALL rise exactly N_CLASS+1 cycles after the edge capturing the final sum (11 cycles at default).
REQ-022 Any Sum_Valid bit asserted in COMPARE or DONE SHALL be ignored, leave the bank unmodified, and pulse Overrun in that cycle.
REQ-023 Sums SHALL be compared as full W-bit signed values, with no truncation or saturation.

Reset
REQ-024 While rst=0, the FSM SHALL be in COLLECT with all flags, idx, best, best_idx, bank registers, Digit, Max_Value, Output_Valid, Busy and Overrun at 0, asynchronously.
REQ-025 Reset asserted mid-COMPARE SHALL abort the frame with no Output_Valid; after release, a full new set of N_CLASS captures SHALL be required.
REQ-026 Sum_Valid on the first edge after reset release SHALL be captured normally.

Structure
REQ-027 A shared package SHALL hold N_CLASS, W, the FSM state encoding, and the Digit width constant (4).
REQ-028 The block SHALL instantiate one sub-module, sum_capture_bank: N_CLASS registers plus flags, with an all_captured output and a clear input.
REQ-029 The comparator and FSM SHALL reside in argmax_classifier.

Verification
REQ-030 All ten valids in one cycle, sums 0..9 ×100 with class 7 = 5000 -> Output_Valid 11 cycles later, Digit=7, Max_Value=5000.
REQ-031 Valids staggered one per cycle in order 9..0, all sums negative, class 3 = -1 and the rest -1000 -> Digit=3, Max_Value=-1 (0x3FFFFFF).
REQ-032 Classes 2 and 6 both = 12345 and the rest 0 -> Digit=2.
REQ-033 Second Sum_Valid[4] in COLLECT with value 77 -> Overrun pulse, 77 used; Sum_Valid[1] during COMPARE -> Overrun pulse, result unchanged.
REQ-034 rst=0 for one cycle at COMPARE idx=5 -> no Output_Valid, Busy=0 immediately; a fresh full frame then yields a correct result 11 cycles after its last capture.
